ch0re_instr_decoder: RTL and testbench
======================================

// Module: ch0re_instr_decoder
// PURPOSE
// - Decode stage of the ch0re RV64I pipeline: turns one 32-bit instruction into register-file addresses, a write
//   enable, the format tag, the ALU op, a sign-extended immediate and the two ALU operand-mux selects.
// - Combinational decode; sits between fetch and the register-file/execute stages. Ports are carried on ch0re_idecoder_intf.
// PARAMETERS
// - XLEN  64  datapath / immediate width
// PORTS
// - i_clk            in   1     clock; no state in this block, kept for pipeline uniformity
// - i_rst            in   1     reset, asynchronous, active-high
// - i_instr          in   32    instruction word
// - o_illegal_instr  out  1     instruction not in the decoded set
// - o_wen            out  1     instruction produces a write (reg for R/I/U/J, memory for S)
// - o_rf_raddr1      out  5     rs1 = i_instr[19:15]
// - o_rf_raddr2      out  5     rs2 = i_instr[24:20]
// - o_rf_waddr       out  5     rd  = i_instr[11:7]
// - o_instr_format   out  enum  IFORMAT_R/I/S/B/U/J
// - o_alu_op         out  enum  ch0re ALU operation
// - o_imm            out  XLEN  sign-extended immediate for the format
// - o_alu_mux1_sel   out  enum  ALU_MUX1_SEL_REG / _PC / _IMM_ZERO
// - o_alu_mux2_sel   out  enum  ALU_MUX2_SEL_REG / _IMM / _IMM_FOUR
// BEHAVIOUR
// - Pure combinational from i_instr; outputs valid within the same delta, no latency, no handshake.
// - i_rst=1 (async, overrides decode): illegal=0, wen=0, addrs=0, format=IFORMAT_R, op=ALU_ADD, imm=0, mux1=REG, mux2=REG.
// - raddr1/raddr2/waddr always the raw fields, whatever the format.
// - R (OP, OP-32): wen=1; mux1=REG, mux2=REG; op from funct3/funct7 (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND, *W).
// - I (OP-IMM, OP-IMM-32, LOAD): wen=1; mux1=REG, mux2=IMM; loads -> ALU_ADD; shifts use shamt (6b, 5b for *W), funct6/7 checked.
// - I JALR: wen=1; mux1=PC, mux2=IMM_FOUR (link = PC+4); op=ALU_ADD; funct3 must be 000.
// - S (STORE sb/sh/sw/sd): wen=1; mux1=REG, mux2=IMM; op=ALU_ADD.
// - B: wen=0; mux1=REG, mux2=REG; beq->SEQ, bne->SNE, blt->SLT, bge->SGE, bltu->SLTU, bgeu->SGEU.
// - J (JAL): wen=1; mux1=PC, mux2=IMM_FOUR; op=ALU_ADD.
// - U: wen=1; op=ALU_ADD, mux2=IMM; LUI mux1=IMM_ZERO, AUIPC mux1=PC; imm = {instr[31:12],12'b0} sign-extended.
// - Immediates: I {[31:20]}, S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, J {[31],[19:12],[20],[30:21],0}; all sign-extended to XLEN.
// - Illegal: instr[1:0]!=2'b11, unknown opcode, undefined funct3/funct7 combo, FENCE/SYSTEM (not handled here)
//   -> illegal=1, wen=0, op=ALU_ADD, imm=0, mux1=REG, mux2=REG; format undefined.
// - Boundary: all-zero and all-one words are illegal; x0 as rd still decodes with wen=1 (regfile drops it).
// STRUCTURE
// - Package ch0re_types: iformat_t, alu_op_t, alu_mux1_sel_t, alu_mux2_sel_t, opcode/funct3/funct7 localparams, XLEN.
// - Interface ch0re_idecoder_intf carries all ports above.
// - One sub-module natural: ch0re_imm_gen (format + instr -> o_imm); the rest is a single always_comb case on opcode.
// TESTING
// - add x2,x1,x3 = 32'h00308133 -> R, wen=1, raddr1=1, raddr2=3, waddr=2, ALU_ADD, mux REG/REG, illegal=0.
// - addi x2,x1,3 = 32'h00308113 -> I, wen=1, raddr1=1, waddr=2, imm=3, ALU_ADD, mux REG/IMM.
// - jalr x2,3(x1) = 32'h00308167 -> I, wen=1, ALU_ADD, mux PC/IMM_FOUR, imm=3.
// - beq x1,x3,+8 = 32'h00308463 -> B, wen=0, raddr1=1, raddr2=3, imm=8, ALU_SEQ, mux REG/REG.
// - lui x2,3 = 32'h00003137 -> U, wen=1, waddr=2, imm=64'h3000, mux IMM_ZERO/IMM; auipc -> mux PC/IMM.
// - 32'h00000000 and bad funct7 on add -> illegal=1, wen=0; assert i_rst mid-decode -> reset values immediately.
// - Sweep every RV64I op: check o_alu_op and o_instr_format against the shared golden instruction table.

Source files
------------

// File: rtl/ch0re_instr_decoder_pkg.sv
// ch0re_types: shared types and encodings for the ch0re RV64I decode stage.
//   XLEN            datapath / immediate width
//   iformat_t       instruction format tag (R/I/S/B/U/J)
//   alu_op_t        ALU operation selected by decode
//   alu_mux1_sel_t  ALU operand A source (register, PC, zero for LUI)
//   alu_mux2_sel_t  ALU operand B source (register, immediate, constant 4)
//   OPC_* / F3_* / F7_*  opcode and function-field encodings
//   base_op()       funct3 -> ALU op for the shared OP / OP-IMM integer group
package ch0re_types;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    IFORMAT_R, IFORMAT_I, IFORMAT_S, IFORMAT_B, IFORMAT_U, IFORMAT_J
  } iformat_t;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    ALU_SEQ, ALU_SNE, ALU_SGE, ALU_SGEU
  } alu_op_t;

  typedef enum logic [1:0] {
    ALU_MUX1_SEL_REG, ALU_MUX1_SEL_PC, ALU_MUX1_SEL_IMM_ZERO
  } alu_mux1_sel_t;

  typedef enum logic [1:0] {
    ALU_MUX2_SEL_REG, ALU_MUX2_SEL_IMM, ALU_MUX2_SEL_IMM_FOUR
  } alu_mux2_sel_t;

  // Full 7-bit opcodes; bits [1:0] are 2'b11, so a compressed or
  // otherwise malformed low pair never matches any of them.
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  // RV64 immediate shifts: funct6 only, bit 25 is shamt[5].
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  function automatic alu_op_t base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: return ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ch0re_instr_decoder_imm_gen.sv
// ch0re_imm_gen: builds the sign-extended immediate for a decoded format.
//   fmt       in   iformat_t   format tag from the decoder
//   instr_hi  in   [31:7]      instruction bits carrying immediate fields
//   imm       out  [XLEN-1:0]  sign-extended immediate (0 for R format)
module ch0re_imm_gen
  import ch0re_types::*;
(
  input  iformat_t               fmt,
  input  logic     [31:7]        instr_hi,
  output logic     [XLEN-1:0]    imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IFORMAT_I: imm = {{(XLEN-12){instr_hi[31]}}, instr_hi[31:20]};
      IFORMAT_S: imm = {{(XLEN-12){instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      IFORMAT_B: imm = {{(XLEN-13){instr_hi[31]}}, instr_hi[31], instr_hi[7],
                        instr_hi[30:25], instr_hi[11:8], 1'b0};
      IFORMAT_U: imm = {{(XLEN-32){instr_hi[31]}}, instr_hi[31:12], 12'b0};
      IFORMAT_J: imm = {{(XLEN-21){instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                        instr_hi[20], instr_hi[30:21], 1'b0};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/ch0re_instr_decoder.sv
// ch0re_instr_decoder: combinational RV64I decode stage.
//   i_clk            in   clock, unused (no state; kept for pipeline uniformity)
//   i_rst            in   async active-high reset, forces neutral outputs
//   i_instr          in   32-bit instruction word
//   o_illegal_instr  out  instruction outside the decoded RV64I set
//   o_wen            out  register write (R/I/U/J) or memory write (S)
//   o_rf_raddr1/2    out  rs1 / rs2 raw fields
//   o_rf_waddr       out  rd raw field
//   o_instr_format   out  format tag
//   o_alu_op         out  ALU operation
//   o_imm            out  sign-extended immediate
//   o_alu_mux1_sel   out  ALU operand A select
//   o_alu_mux2_sel   out  ALU operand B select
module ch0re_instr_decoder
  import ch0re_types::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [31:0]          i_instr,
  output logic                 o_illegal_instr,
  output logic                 o_wen,
  output logic [4:0]           o_rf_raddr1,
  output logic [4:0]           o_rf_raddr2,
  output logic [4:0]           o_rf_waddr,
  output iformat_t             o_instr_format,
  output alu_op_t              o_alu_op,
  output logic [XLEN-1:0]      o_imm,
  output alu_mux1_sel_t        o_alu_mux1_sel,
  output alu_mux2_sel_t        o_alu_mux2_sel
);

  logic unused_clk;
  assign unused_clk = i_clk;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] f6;
  assign opcode = i_instr[6:0];
  assign f3     = i_instr[14:12];
  assign f7     = i_instr[31:25];
  assign f6     = i_instr[31:26];

  logic          illegal;
  logic          wen;
  iformat_t      fmt;
  alu_op_t       op;
  alu_mux1_sel_t mux1;
  alu_mux2_sel_t mux2;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    illegal = 1'b0;
    wen     = 1'b1;
    fmt     = IFORMAT_R;
    op      = ALU_ADD;
    mux1    = ALU_MUX1_SEL_REG;
    mux2    = ALU_MUX2_SEL_REG;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE)                          op = base_op(f3);
        else if (f7 == F7_ALT && f3 == F3_ADD_SUB)  op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == F3_SRL_SRA)  op = ALU_SRA;
        else                                        illegal = 1'b1;
      end
      OPC_OP_32: begin
        case ({f7 == F7_ALT, f7 == F7_BASE, f3})
          {2'b01, F3_ADD_SUB}: op = ALU_ADDW;
          {2'b01, F3_SLL}:     op = ALU_SLLW;
          {2'b01, F3_SRL_SRA}: op = ALU_SRLW;
          {2'b10, F3_ADD_SUB}: op = ALU_SUBW;
          {2'b10, F3_SRL_SRA}: op = ALU_SRAW;
          default:             illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        fmt  = IFORMAT_I;
        mux2 = ALU_MUX2_SEL_IMM;
        op   = base_op(f3);
        if (f3 == F3_SLL && f6 != F6_BASE) illegal = 1'b1;
        if (f3 == F3_SRL_SRA) begin
          if (f6 == F6_ALT)        op = ALU_SRA;
          else if (f6 != F6_BASE)  illegal = 1'b1;
        end
      end
      OPC_OP_IMM_32: begin
        fmt  = IFORMAT_I;
        mux2 = ALU_MUX2_SEL_IMM;
        case (f3)
          F3_ADD_SUB: op = ALU_ADDW;
          F3_SLL:     if (f7 == F7_BASE) op = ALU_SLLW; else illegal = 1'b1;
          F3_SRL_SRA: begin
            if (f7 == F7_BASE)      op = ALU_SRLW;
            else if (f7 == F7_ALT)  op = ALU_SRAW;
            else                    illegal = 1'b1;
          end
          default:    illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt  = IFORMAT_I;
        mux2 = ALU_MUX2_SEL_IMM;
        if (f3 == 3'b111) illegal = 1'b1;   // no 64-bit unsigned load
      end
      OPC_JALR: begin
        fmt  = IFORMAT_I;
        mux1 = ALU_MUX1_SEL_PC;
        mux2 = ALU_MUX2_SEL_IMM_FOUR;       // ALU produces the link PC+4
        if (f3 != 3'b000) illegal = 1'b1;
      end
      OPC_STORE: begin
        fmt  = IFORMAT_S;
        mux2 = ALU_MUX2_SEL_IMM;
        if (f3[2]) illegal = 1'b1;          // sb/sh/sw/sd only
      end
      OPC_BRANCH: begin
        fmt = IFORMAT_B;
        wen = 1'b0;
        case (f3)
          F3_BEQ:  op = ALU_SEQ;
          F3_BNE:  op = ALU_SNE;
          F3_BLT:  op = ALU_SLT;
          F3_BGE:  op = ALU_SGE;
          F3_BLTU: op = ALU_SLTU;
          F3_BGEU: op = ALU_SGEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        fmt  = IFORMAT_J;
        mux1 = ALU_MUX1_SEL_PC;
        mux2 = ALU_MUX2_SEL_IMM_FOUR;
      end
      OPC_LUI: begin
        fmt  = IFORMAT_U;
        mux1 = ALU_MUX1_SEL_IMM_ZERO;
        mux2 = ALU_MUX2_SEL_IMM;
      end
      OPC_AUIPC: begin
        fmt  = IFORMAT_U;
        mux1 = ALU_MUX1_SEL_PC;
        mux2 = ALU_MUX2_SEL_IMM;
      end
      default: illegal = 1'b1;              // incl. FENCE, SYSTEM, bits[1:0]!=11
    endcase

    // An illegal word must not write or steer the datapath anywhere useful.
    if (illegal) begin
      wen  = 1'b0;
      op   = ALU_ADD;
      mux1 = ALU_MUX1_SEL_REG;
      mux2 = ALU_MUX2_SEL_REG;
    end
  end

  logic [XLEN-1:0] imm_raw;

  ch0re_imm_gen u_imm_gen (
    .fmt      (fmt),
    .instr_hi (i_instr[31:7]),
    .imm      (imm_raw)
  );

  // Reset overrides decode combinationally, so it takes effect with no clock.
  always_comb begin
    o_illegal_instr = illegal & ~i_rst;
    o_wen           = wen & ~i_rst;
    o_rf_raddr1     = i_rst ? 5'd0 : i_instr[19:15];
    o_rf_raddr2     = i_rst ? 5'd0 : i_instr[24:20];
    o_rf_waddr      = i_rst ? 5'd0 : i_instr[11:7];
    o_instr_format  = i_rst ? IFORMAT_R : fmt;
    o_alu_op        = i_rst ? ALU_ADD : op;
    o_imm           = (i_rst || illegal) ? '0 : imm_raw;
    o_alu_mux1_sel  = i_rst ? ALU_MUX1_SEL_REG : mux1;
    o_alu_mux2_sel  = i_rst ? ALU_MUX2_SEL_REG : mux2;
  end

endmodule

// File: tb/tb_ch0re_instr_decoder.sv
module tb_ch0re_instr_decoder;
  import ch0re_types::*;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic [31:0]     i_instr = 32'h0;
  logic            o_illegal_instr;
  logic            o_wen;
  logic [4:0]      o_rf_raddr1;
  logic [4:0]      o_rf_raddr2;
  logic [4:0]      o_rf_waddr;
  iformat_t        o_instr_format;
  alu_op_t         o_alu_op;
  logic [XLEN-1:0] o_imm;
  alu_mux1_sel_t   o_alu_mux1_sel;
  alu_mux2_sel_t   o_alu_mux2_sel;

  int total = 0;
  int bad   = 0;

  ch0re_instr_decoder dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_instr         (i_instr),
    .o_illegal_instr (o_illegal_instr),
    .o_wen           (o_wen),
    .o_rf_raddr1     (o_rf_raddr1),
    .o_rf_raddr2     (o_rf_raddr2),
    .o_rf_waddr      (o_rf_waddr),
    .o_instr_format  (o_instr_format),
    .o_alu_op        (o_alu_op),
    .o_imm           (o_imm),
    .o_alu_mux1_sel  (o_alu_mux1_sel),
    .o_alu_mux2_sel  (o_alu_mux2_sel)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] instr;
    iformat_t    fmt;
    alu_op_t     op;
  } golden_t;

  golden_t golden[$];

  // rd=2, rs1=1, rs2=3 in every generated word.
  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] opc);
    return {f7, 5'd3, 5'd1, f3, 5'd2, opc};
  endfunction

  task automatic drive(input logic [31:0] w);
    @(negedge i_clk);
    i_instr = w;
    #1;
  endtask

  task automatic add_g(input logic [31:0] w, input iformat_t f, input alu_op_t o);
    golden_t g;
    g.instr = w; g.fmt = f; g.op = o;
    golden.push_back(g);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drive(32'h00308133);
    total++;
    if ({o_illegal_instr, o_wen, o_rf_raddr1, o_rf_raddr2, o_rf_waddr} !== 17'd0 ||
        o_imm !== 64'd0) begin
      bad++;
      $display("FAIL reset_fields got ill=%b wen=%b a1=%0d a2=%0d wa=%0d imm=%h want all zero",
               o_illegal_instr, o_wen, o_rf_raddr1, o_rf_raddr2, o_rf_waddr, o_imm);
    end
    total++;
    if (o_instr_format !== IFORMAT_R || o_alu_op !== ALU_ADD ||
        o_alu_mux1_sel !== ALU_MUX1_SEL_REG || o_alu_mux2_sel !== ALU_MUX2_SEL_REG) begin
      bad++;
      $display("FAIL reset_enums got fmt=%0d op=%0d m1=%0d m2=%0d want 0/0/0/0",
               o_instr_format, o_alu_op, o_alu_mux1_sel, o_alu_mux2_sel);
    end
    drive(32'h00000000);
    total++;
    if (o_illegal_instr !== 1'b0 || o_wen !== 1'b0) begin
      bad++;
      $display("FAIL reset_illegal_word got ill=%b wen=%b want 0 0", o_illegal_instr, o_wen);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_r_type();
    drive(32'h00308133);   // add x2,x1,x3
    total++;
    if ({o_illegal_instr, o_wen, o_rf_raddr1, o_rf_raddr2, o_rf_waddr} !== {2'b01, 5'd1, 5'd3, 5'd2}) begin
      bad++;
      $display("FAIL add_fields got ill=%b wen=%b a1=%0d a2=%0d wa=%0d want 0 1 1 3 2",
               o_illegal_instr, o_wen, o_rf_raddr1, o_rf_raddr2, o_rf_waddr);
    end
    total++;
    if (o_instr_format !== IFORMAT_R || o_alu_op !== ALU_ADD ||
        o_alu_mux1_sel !== ALU_MUX1_SEL_REG || o_alu_mux2_sel !== ALU_MUX2_SEL_REG) begin
      bad++;
      $display("FAIL add_ctrl got fmt=%0d op=%0d m1=%0d m2=%0d want R ADD REG REG",
               o_instr_format, o_alu_op, o_alu_mux1_sel, o_alu_mux2_sel);
    end
  endtask

  task automatic test_i_type();
    drive(32'h00308113);   // addi x2,x1,3
    total++;
    if (o_instr_format !== IFORMAT_I || o_wen !== 1'b1 || o_rf_raddr1 !== 5'd1 ||
        o_rf_waddr !== 5'd2 || o_imm !== 64'd3 || o_alu_op !== ALU_ADD ||
        o_alu_mux1_sel !== ALU_MUX1_SEL_REG || o_alu_mux2_sel !== ALU_MUX2_SEL_IMM) begin
      bad++;
      $display("FAIL addi got fmt=%0d wen=%b a1=%0d wa=%0d imm=%h op=%0d m1=%0d m2=%0d",
               o_instr_format, o_wen, o_rf_raddr1, o_rf_waddr, o_imm, o_alu_op,
               o_alu_mux1_sel, o_alu_mux2_sel);
    end
    drive(32'hFFF00093);   // addi x1,x0,-1
    total++;
    if (o_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL addi_neg_imm got=%h want=ffffffffffffffff", o_imm);
    end
    drive(32'h43F0D093);   // srai x1,x1,63
    total++;
    if (o_alu_op !== ALU_SRA || o_illegal_instr !== 1'b0 || o_imm !== 64'h43F) begin
      bad++;
      $display("FAIL srai63 got op=%0d ill=%b imm=%h want SRA 0 43f", o_alu_op, o_illegal_instr, o_imm);
    end
    drive(32'h00000013);   // addi x0,x0,0: rd=x0 still writes
    total++;
    if (o_wen !== 1'b1 || o_rf_waddr !== 5'd0 || o_illegal_instr !== 1'b0) begin
      bad++;
      $display("FAIL x0_rd got wen=%b wa=%0d ill=%b want 1 0 0", o_wen, o_rf_waddr, o_illegal_instr);
    end
  endtask

  task automatic test_jumps();
    drive(32'h00308167);   // jalr x2,3(x1)
    total++;
    if (o_instr_format !== IFORMAT_I || o_wen !== 1'b1 || o_alu_op !== ALU_ADD || o_imm !== 64'd3 ||
        o_alu_mux1_sel !== ALU_MUX1_SEL_PC || o_alu_mux2_sel !== ALU_MUX2_SEL_IMM_FOUR) begin
      bad++;
      $display("FAIL jalr got fmt=%0d wen=%b op=%0d imm=%h m1=%0d m2=%0d",
               o_instr_format, o_wen, o_alu_op, o_imm, o_alu_mux1_sel, o_alu_mux2_sel);
    end
    drive(32'hFFDFF0EF);   // jal x1,-4
    total++;
    if (o_instr_format !== IFORMAT_J || o_wen !== 1'b1 || o_rf_waddr !== 5'd1 ||
        o_imm !== 64'hFFFF_FFFF_FFFF_FFFC ||
        o_alu_mux1_sel !== ALU_MUX1_SEL_PC || o_alu_mux2_sel !== ALU_MUX2_SEL_IMM_FOUR) begin
      bad++;
      $display("FAIL jal got fmt=%0d wen=%b wa=%0d imm=%h m1=%0d m2=%0d",
               o_instr_format, o_wen, o_rf_waddr, o_imm, o_alu_mux1_sel, o_alu_mux2_sel);
    end
  endtask

  task automatic test_branch_store();
    drive(32'h00308463);   // beq x1,x3,+8
    total++;
    if (o_instr_format !== IFORMAT_B || o_wen !== 1'b0 || o_rf_raddr1 !== 5'd1 ||
        o_rf_raddr2 !== 5'd3 || o_imm !== 64'd8 || o_alu_op !== ALU_SEQ ||
        o_alu_mux1_sel !== ALU_MUX1_SEL_REG || o_alu_mux2_sel !== ALU_MUX2_SEL_REG) begin
      bad++;
      $display("FAIL beq got fmt=%0d wen=%b a1=%0d a2=%0d imm=%h op=%0d m1=%0d m2=%0d",
               o_instr_format, o_wen, o_rf_raddr1, o_rf_raddr2, o_imm, o_alu_op,
               o_alu_mux1_sel, o_alu_mux2_sel);
    end
    drive(32'hFE20BC23);   // sd x2,-8(x1)
    total++;
    if (o_instr_format !== IFORMAT_S || o_wen !== 1'b1 || o_imm !== 64'hFFFF_FFFF_FFFF_FFF8 ||
        o_alu_op !== ALU_ADD || o_alu_mux2_sel !== ALU_MUX2_SEL_IMM) begin
      bad++;
      $display("FAIL sd got fmt=%0d wen=%b imm=%h op=%0d m2=%0d",
               o_instr_format, o_wen, o_imm, o_alu_op, o_alu_mux2_sel);
    end
  endtask

  task automatic test_u_type();
    drive(32'h00003137);   // lui x2,3
    total++;
    if (o_instr_format !== IFORMAT_U || o_wen !== 1'b1 || o_rf_waddr !== 5'd2 ||
        o_imm !== 64'h3000 || o_alu_mux1_sel !== ALU_MUX1_SEL_IMM_ZERO ||
        o_alu_mux2_sel !== ALU_MUX2_SEL_IMM) begin
      bad++;
      $display("FAIL lui got fmt=%0d wen=%b wa=%0d imm=%h m1=%0d m2=%0d",
               o_instr_format, o_wen, o_rf_waddr, o_imm, o_alu_mux1_sel, o_alu_mux2_sel);
    end
    drive(32'h80000117);   // auipc x2,0x80000 (sign bit set)
    total++;
    if (o_imm !== 64'hFFFF_FFFF_8000_0000 || o_alu_mux1_sel !== ALU_MUX1_SEL_PC ||
        o_alu_mux2_sel !== ALU_MUX2_SEL_IMM || o_alu_op !== ALU_ADD) begin
      bad++;
      $display("FAIL auipc got imm=%h m1=%0d m2=%0d op=%0d", o_imm, o_alu_mux1_sel,
               o_alu_mux2_sel, o_alu_op);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [12];
    words = '{32'h00000000, 32'hFFFFFFFF, 32'h02308133, 32'h0000000F,
              32'h00000073, 32'h4210D09B, enc(7'h01, 3'b001, OPC_OP_IMM_32),
              32'h00309167, enc(7'h00, 3'b111, OPC_LOAD), enc(7'h00, 3'b010, OPC_BRANCH),
              32'h40309133, 32'h00308131};
    foreach (words[k]) begin
      drive(words[k]);
      total++;
      if (o_illegal_instr !== 1'b1 || o_wen !== 1'b0 || o_alu_op !== ALU_ADD ||
          o_imm !== 64'd0 || o_alu_mux1_sel !== ALU_MUX1_SEL_REG ||
          o_alu_mux2_sel !== ALU_MUX2_SEL_REG) begin
        bad++;
        $display("FAIL illegal[%0d] instr=%h got ill=%b wen=%b op=%0d imm=%h m1=%0d m2=%0d want 1 0 ADD 0 REG REG",
                 k, words[k], o_illegal_instr, o_wen, o_alu_op, o_imm,
                 o_alu_mux1_sel, o_alu_mux2_sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(32'h00308133);
    #1 i_rst = 1'b1;
    #1;
    total++;
    if (o_wen !== 1'b0 || o_rf_waddr !== 5'd0 || o_alu_op !== ALU_ADD || o_rf_raddr2 !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset got wen=%b wa=%0d op=%0d a2=%0d want 0 0 ADD 0",
               o_wen, o_rf_waddr, o_alu_op, o_rf_raddr2);
    end
    i_rst = 1'b0;
    #1;
    total++;
    if (o_wen !== 1'b1 || o_rf_waddr !== 5'd2 || o_rf_raddr2 !== 5'd3) begin
      bad++;
      $display("FAIL post_reset got wen=%b wa=%0d a2=%0d want 1 2 3", o_wen, o_rf_waddr, o_rf_raddr2);
    end
    drive(32'h40308133);   // sub directly after add
    total++;
    if (o_alu_op !== ALU_SUB || o_illegal_instr !== 1'b0) begin
      bad++;
      $display("FAIL sub_after_add got op=%0d ill=%b want SUB 0", o_alu_op, o_illegal_instr);
    end
  endtask

  task automatic test_sweep();
    add_g(enc(7'h00, 3'b000, OPC_OP), IFORMAT_R, ALU_ADD);
    add_g(enc(7'h20, 3'b000, OPC_OP), IFORMAT_R, ALU_SUB);
    add_g(enc(7'h00, 3'b001, OPC_OP), IFORMAT_R, ALU_SLL);
    add_g(enc(7'h00, 3'b010, OPC_OP), IFORMAT_R, ALU_SLT);
    add_g(enc(7'h00, 3'b011, OPC_OP), IFORMAT_R, ALU_SLTU);
    add_g(enc(7'h00, 3'b100, OPC_OP), IFORMAT_R, ALU_XOR);
    add_g(enc(7'h00, 3'b101, OPC_OP), IFORMAT_R, ALU_SRL);
    add_g(enc(7'h20, 3'b101, OPC_OP), IFORMAT_R, ALU_SRA);
    add_g(enc(7'h00, 3'b110, OPC_OP), IFORMAT_R, ALU_OR);
    add_g(enc(7'h00, 3'b111, OPC_OP), IFORMAT_R, ALU_AND);
    add_g(enc(7'h00, 3'b000, OPC_OP_32), IFORMAT_R, ALU_ADDW);
    add_g(enc(7'h20, 3'b000, OPC_OP_32), IFORMAT_R, ALU_SUBW);
    add_g(enc(7'h00, 3'b001, OPC_OP_32), IFORMAT_R, ALU_SLLW);
    add_g(enc(7'h00, 3'b101, OPC_OP_32), IFORMAT_R, ALU_SRLW);
    add_g(enc(7'h20, 3'b101, OPC_OP_32), IFORMAT_R, ALU_SRAW);
    add_g(enc(7'h7F, 3'b000, OPC_OP_IMM), IFORMAT_I, ALU_ADD);
    add_g(enc(7'h00, 3'b010, OPC_OP_IMM), IFORMAT_I, ALU_SLT);
    add_g(enc(7'h00, 3'b011, OPC_OP_IMM), IFORMAT_I, ALU_SLTU);
    add_g(enc(7'h00, 3'b100, OPC_OP_IMM), IFORMAT_I, ALU_XOR);
    add_g(enc(7'h00, 3'b110, OPC_OP_IMM), IFORMAT_I, ALU_OR);
    add_g(enc(7'h00, 3'b111, OPC_OP_IMM), IFORMAT_I, ALU_AND);
    add_g(enc(7'h01, 3'b001, OPC_OP_IMM), IFORMAT_I, ALU_SLL);   // shamt[5]=1
    add_g(enc(7'h01, 3'b101, OPC_OP_IMM), IFORMAT_I, ALU_SRL);
    add_g(enc(7'h21, 3'b101, OPC_OP_IMM), IFORMAT_I, ALU_SRA);
    add_g(enc(7'h55, 3'b000, OPC_OP_IMM_32), IFORMAT_I, ALU_ADDW);
    add_g(enc(7'h00, 3'b001, OPC_OP_IMM_32), IFORMAT_I, ALU_SLLW);
    add_g(enc(7'h00, 3'b101, OPC_OP_IMM_32), IFORMAT_I, ALU_SRLW);
    add_g(enc(7'h20, 3'b101, OPC_OP_IMM_32), IFORMAT_I, ALU_SRAW);
    for (int f = 0; f < 7; f++)
      add_g(enc(7'h00, 3'(f), OPC_LOAD), IFORMAT_I, ALU_ADD);
    for (int f = 0; f < 4; f++)
      add_g(enc(7'h00, 3'(f), OPC_STORE), IFORMAT_S, ALU_ADD);
    add_g(enc(7'h00, 3'b000, OPC_BRANCH), IFORMAT_B, ALU_SEQ);
    add_g(enc(7'h00, 3'b001, OPC_BRANCH), IFORMAT_B, ALU_SNE);
    add_g(enc(7'h00, 3'b100, OPC_BRANCH), IFORMAT_B, ALU_SLT);
    add_g(enc(7'h00, 3'b101, OPC_BRANCH), IFORMAT_B, ALU_SGE);
    add_g(enc(7'h00, 3'b110, OPC_BRANCH), IFORMAT_B, ALU_SLTU);
    add_g(enc(7'h00, 3'b111, OPC_BRANCH), IFORMAT_B, ALU_SGEU);
    add_g(enc(7'h12, 3'b011, OPC_JAL), IFORMAT_J, ALU_ADD);
    add_g(enc(7'h00, 3'b000, OPC_JALR), IFORMAT_I, ALU_ADD);
    add_g(enc(7'h12, 3'b101, OPC_LUI), IFORMAT_U, ALU_ADD);
    add_g(enc(7'h12, 3'b101, OPC_AUIPC), IFORMAT_U, ALU_ADD);
    foreach (golden[k]) begin
      drive(golden[k].instr);
      total++;
      if (o_instr_format !== golden[k].fmt || o_alu_op !== golden[k].op ||
          o_illegal_instr !== 1'b0) begin
        bad++;
        $display("FAIL sweep[%0d] instr=%h got fmt=%0d op=%0d ill=%b want fmt=%0d op=%0d ill=0",
                 k, golden[k].instr, o_instr_format, o_alu_op, o_illegal_instr,
                 golden[k].fmt, golden[k].op);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_i_type();
    test_jumps();
    test_branch_store();
    test_u_type();
    test_illegal();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
